// File: rtl/gf180mcu_fd_sc_mcu9t5v0_rst_seq_pkg.sv
// Shared types and helpers for the reset synchroniser/sequencer.
// Holds the sequencer state encoding, the output-count ceiling and the counter-width helper.
package gf180mcu_fd_sc_mcu9t5v0_rst_seq_pkg;

    localparam int RSTSEQ_MAX_OUT = 8;

    // Encoding is visible on DBG_STATE, so the values are fixed.
    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rstseq_state_e;

    function automatic int rstseq_cnt_width(input int hold_cycles, input int stage_gap);
        int longest;
        longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_rst_sync.sv
// Reset synchroniser: STAGES-deep flop chain, cleared asynchronously by RN.
// Q[1] is the last stage; Q[0] is the value the last stage samples on the next edge.
module gf180mcu_fd_sc_mcu9t5v0_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       D,
    output logic [1:0] Q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], D};
        end
    end

    assign Q = chain_q[STAGES-1:STAGES-2];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_rst_seq.sv
// Reset sequencer: synchronised release, programmable hold, staggered RSTN_OUT release, READY.
// Define GF180MCU_FD_SC_MCU9T5V0_RST_SEQ_DBG_EN to expose DBG_STATE and DBG_CNT.
module gf180mcu_fd_sc_mcu9t5v0_rst_seq
    import gf180mcu_fd_sc_mcu9t5v0_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               D,
    input  logic               SW_RSTN,
    output logic [NUM_OUT-1:0] RSTN_OUT,
    output logic               READY
`ifdef GF180MCU_FD_SC_MCU9T5V0_RST_SEQ_DBG_EN
    ,
    output logic [1:0]         DBG_STATE,
    output logic [rstseq_cnt_width(HOLD_CYCLES, STAGE_GAP)-1:0] DBG_CNT
`endif
);

    localparam int CNT_W = rstseq_cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT);

    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
        NUM_OUT < 1 || NUM_OUT > RSTSEQ_MAX_OUT) begin : g_bad_params
        $error("rst_seq: parameter out of range");
    end

    logic [1:0]         sync_q;
    logic               sync_next;
    logic               sync_out;

    rstseq_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_OUT-1:0] rstn_q;
    logic [NUM_OUT-1:0] rstn_d;
    logic               ready_q;

    gf180mcu_fd_sc_mcu9t5v0_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RN  (RN),
        .D   (D),
        .Q   (sync_q)
    );

    assign sync_next = sync_q[0];
    assign sync_out  = sync_q[1];

    // Saturating increment; every state that counts clears cnt on its exit edge.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Thermometer mask with bits 0..idx_q set: releases the next output in line.
    always_comb begin
        rstn_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            rstn_d[i] = (i <= int'(idx_q));
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    // Leave on the edge where the last stage captures 1.
                    if (sync_next) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (!sync_out) begin
                        state_q <= ST_SYNC;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        rstn_q  <= '0;
                        ready_q <= 1'b0;
                    end else if (!SW_RSTN) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        rstn_q  <= '0;
                        ready_q <= 1'b0;
                    end else begin
                        case (state_q)
                            ST_HOLD: begin
                                if (cnt_q == HOLD_LAST) begin
                                    state_q <= ST_RELEASE;
                                    cnt_q   <= '0;
                                    idx_q   <= IDX_W'(1);
                                    rstn_q  <= NUM_OUT'(1);
                                end else begin
                                    cnt_q <= cnt_d;
                                end
                            end
                            ST_RELEASE: begin
                                if (cnt_q == GAP_LAST) begin
                                    cnt_q <= '0;
                                    if (idx_q == IDX_LAST) begin
                                        state_q <= ST_RUN;
                                        ready_q <= 1'b1;
                                    end else begin
                                        rstn_q <= rstn_d;
                                        idx_q  <= idx_q + IDX_W'(1);
                                    end
                                end else begin
                                    cnt_q <= cnt_d;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign RSTN_OUT = rstn_q;
    assign READY    = ready_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0_RST_SEQ_DBG_EN
    assign DBG_STATE = state_q;
    assign DBG_CNT   = cnt_q;
`endif

endmodule
